// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, sync-polarity encodings and counter-width helper
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned h_total,
                                            input int unsigned v_total);
    int unsigned m;
    m = (h_total > v_total) ? h_total : v_total;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the generator to framebuffer/pixel-output stages.
// frame_cnt_o exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic             hsync_o;
  logic             vsync_o;
  logic             video_on_o;
  logic [CNT_W-1:0] pixel_x_o;
  logic [CNT_W-1:0] pixel_y_o;
  logic             line_start_o;
  logic             frame_start_o;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]      frame_cnt_o;
`endif

  modport master (
    output hsync_o, vsync_o, video_on_o, pixel_x_o, pixel_y_o,
           line_start_o, frame_start_o
`ifdef VGA_FRAME_CNT_EN
  , output frame_cnt_o
`endif
  );

  modport slave (
    input  hsync_o, vsync_o, video_on_o, pixel_x_o, pixel_y_o,
           line_start_o, frame_start_o
`ifdef VGA_FRAME_CNT_EN
  , input  frame_cnt_o
`endif
  );
endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enabled modulo counter that resets to MAX so its first enabled edge wraps to 0.
module wrap_counter #(
  parameter int unsigned MAX = 799,
  parameter int unsigned W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_comb begin
    wrap_o = en_i && (cnt_o == MAX_V);
  end

  always_ff @(posedge clk_i or negedge rst_) begin
    if (!rst_) begin
      cnt_o <= MAX_V;
    end else if (en_i) begin
      cnt_o <= wrap_o ? '0 : cnt_o + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA display timing generator: all outputs are flops loaded from the next
// counter position. Optional frame counter under VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_W     = cnt_width(DEF_H_TOTAL, DEF_V_TOTAL)
) (
  input  logic clk_i,
  input  logic rst_,
  vga_timing_gen_if.master vid
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_V  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_V  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             hs_nxt, vs_nxt, frame_nxt;

  wrap_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_h_cnt (
    .clk_i  (clk_i),
    .rst_   (rst_),
    .en_i   (1'b1),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_v_cnt (
    .clk_i  (clk_i),
    .rst_   (rst_),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  // Mirror the counters' next state so outputs land on the same edge the counters move.
  always_comb begin
    h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
    end
    hs_nxt    = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt    = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    frame_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk_i or negedge rst_) begin
    if (!rst_) begin
      vid.hsync_o       <= ~SYNC_POL;
      vid.vsync_o       <= ~SYNC_POL;
      vid.video_on_o    <= 1'b0;
      vid.pixel_x_o     <= '0;
      vid.pixel_y_o     <= '0;
      vid.line_start_o  <= 1'b0;
      vid.frame_start_o <= 1'b0;
    end else begin
      vid.hsync_o       <= hs_nxt;
      vid.vsync_o       <= vs_nxt;
      vid.video_on_o    <= (h_nxt < H_VIS_V) && (v_nxt < V_VIS_V);
      vid.pixel_x_o     <= h_nxt;
      vid.pixel_y_o     <= v_nxt;
      vid.line_start_o  <= (h_nxt == '0);
      vid.frame_start_o <= frame_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic frame_seen;

  // The first frame after reset is frame 0; later frame starts advance the count.
  always_ff @(posedge clk_i or negedge rst_) begin
    if (!rst_) begin
      frame_seen      <= 1'b0;
      vid.frame_cnt_o <= '0;
    end else if (frame_nxt) begin
      frame_seen <= 1'b1;
      if (frame_seen) begin
        vid.frame_cnt_o <= vid.frame_cnt_o + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced 32x19 raster so whole
// frames fit in a short run. Frame counter checks apply when VGA_FRAME_CNT_EN is set.
module tb_vga_timing_gen;
  localparam int TH_VIS = 16, TH_FP = 4, TH_SYNC = 6, TH_BP = 6;
  localparam int TV_VIS = 12, TV_FP = 2, TV_SYNC = 2, TV_BP = 3;
  localparam int TH_TOT = TH_VIS + TH_FP + TH_SYNC + TH_BP;   // 32
  localparam int TV_TOT = TV_VIS + TV_FP + TV_SYNC + TV_BP;   // 19
  localparam int HS_A = TH_VIS + TH_FP;                       // 20
  localparam int HS_B = TH_VIS + TH_FP + TH_SYNC - 1;         // 25
  localparam int VS_A = TV_VIS + TV_FP;                       // 14
  localparam int VS_B = TV_VIS + TV_FP + TV_SYNC - 1;         // 15

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_  = 1'b0;

  vga_timing_gen_if #(.CNT_W(10)) vid ();

  vga_timing_gen #(
    .H_VISIBLE (TH_VIS), .H_FP (TH_FP), .H_SYNC (TH_SYNC), .H_BP (TH_BP),
    .V_VISIBLE (TV_VIS), .V_FP (TV_FP), .V_SYNC (TV_SYNC), .V_BP (TV_BP),
    .SYNC_POL  (1'b0),   .CNT_W (10)
  ) dut (
    .clk_i (clk_i),
    .rst_  (rst_),
    .vid   (vid)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster model: pushes what the outputs must show after each edge.
  exp_t sb[$];
  bit   m_run = 0;
  bit   m_fs_seen = 0;
  int   mx = 0, my = 0, m_fc = 0;

  always @(negedge rst_) begin
    m_run = 0;
    m_fs_seen = 0;
    m_fc = 0;
    sb.delete();
  end

  always @(posedge clk_i) begin
    exp_t e;
    if (rst_) begin
      if (!m_run) begin
        mx = 0;
        my = 0;
        m_run = 1;
      end else begin
        mx = mx + 1;
        if (mx == TH_TOT) begin
          mx = 0;
          my = my + 1;
          if (my == TV_TOT) my = 0;
        end
      end
      if (mx == 0 && my == 0) begin
        if (m_fs_seen) m_fc = (m_fc + 1) % 65536;
        m_fs_seen = 1;
      end
      e.x   = mx;
      e.y   = my;
      e.hs  = !(mx >= HS_A && mx <= HS_B);
      e.vs  = !(my >= VS_A && my <= VS_B);
      e.von = (mx < TH_VIS) && (my < TV_VIS);
      e.ls  = (mx == 0);
      e.fs  = (mx == 0) && (my == 0);
      e.fc  = m_fc;
      sb.push_back(e);
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pixel_x", vid.pixel_x_o, e.x);
      chk("pixel_y", vid.pixel_y_o, e.y);
      chk("hsync", vid.hsync_o, e.hs);
      chk("vsync", vid.vsync_o, e.vs);
      chk("video_on", vid.video_on_o, e.von);
      chk("line_start", vid.line_start_o, e.ls);
      chk("frame_start", vid.frame_start_o, e.fs);
`ifdef VGA_FRAME_CNT_EN
      if (e.fs) chk("frame_cnt", vid.frame_cnt_o, e.fc);
`endif
    end
  end

  // Period / pulse-width monitors, independent of the scoreboard.
  int  cyc = 0;
  int  last_ls = -1, last_fs = -1, hs_low = 0, y_max = 0;
  bit  hs_cnt_valid = 0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_) begin
      last_ls = -1;
      last_fs = -1;
      hs_cnt_valid = 0;
      hs_low = 0;
    end else begin
      if (vid.line_start_o) begin
        if (last_ls >= 0) chk("line_period", cyc - last_ls, TH_TOT);
        if (hs_cnt_valid) chk("hsync_width", hs_low, TH_SYNC);
        last_ls = cyc;
        hs_low = 0;
        hs_cnt_valid = 1;
      end
      if (vid.frame_start_o) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, TH_TOT * TV_TOT);
        last_fs = cyc;
      end
      if (!vid.hsync_o) hs_low++;
      if (int'(vid.pixel_y_o) > y_max) y_max = int'(vid.pixel_y_o);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hsync"}, vid.hsync_o, 1);
    chk({tag, "_vsync"}, vid.vsync_o, 1);
    chk({tag, "_video_on"}, vid.video_on_o, 0);
    chk({tag, "_pixel_x"}, vid.pixel_x_o, 0);
    chk({tag, "_pixel_y"}, vid.pixel_y_o, 0);
    chk({tag, "_line_start"}, vid.line_start_o, 0);
    chk({tag, "_frame_start"}, vid.frame_start_o, 0);
`ifdef VGA_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, vid.frame_cnt_o, 0);
`endif
  endtask

  task automatic release_and_check_origin(input string tag);
    @(negedge clk_i);
    rst_ = 1'b1;
    @(negedge clk_i);
    chk({tag, "_x0"}, vid.pixel_x_o, 0);
    chk({tag, "_y0"}, vid.pixel_y_o, 0);
    chk({tag, "_von"}, vid.video_on_o, 1);
    chk({tag, "_ls"}, vid.line_start_o, 1);
    chk({tag, "_fs"}, vid.frame_start_o, 1);
  endtask

  initial begin
    bit found;

    repeat (5) @(negedge clk_i);
    check_reset_vals("rst");
    release_and_check_origin("start");

    repeat (2 * TH_TOT * TV_TOT + 40) @(negedge clk_i);

    // Wrap corner: last pixel of the frame must be followed by the origin.
    found = 0;
    for (int i = 0; i < 2 * TH_TOT * TV_TOT && !found; i++) begin
      @(negedge clk_i);
      if (vid.pixel_x_o == 10'(TH_TOT - 1) && vid.pixel_y_o == 10'(TV_TOT - 1)) found = 1;
    end
    chk("wrap_corner_found", found, 1);
    if (found) begin
      @(negedge clk_i);
      chk("wrap_x", vid.pixel_x_o, 0);
      chk("wrap_y", vid.pixel_y_o, 0);
      chk("wrap_ls", vid.line_start_o, 1);
      chk("wrap_fs", vid.frame_start_o, 1);
    end

    // Mid-frame reset: outputs must clear before the next clock edge.
    found = 0;
    for (int i = 0; i < 2 * TH_TOT * TV_TOT && !found; i++) begin
      @(negedge clk_i);
      if (vid.pixel_x_o == 10'd10 && vid.pixel_y_o == 10'd8) found = 1;
    end
    chk("mid_pos_found", found, 1);
    #2 rst_ = 1'b0;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge clk_i);
    check_reset_vals("held_rst");
    release_and_check_origin("restart");

    repeat (3 * TH_TOT * TV_TOT + 10) @(negedge clk_i);
    chk("pixel_y_max", y_max, TV_TOT - 1);
    chk("scoreboard_drained", sb.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing generator fed by the divided pixel clock; its clk_i is driven by the clock divider's clk_o.
- Produces horizontal and vertical sync, the active-video flag, the current pixel coordinates, and line/frame strobes.
- Downstream consumers are the framebuffer read and pixel-output stages.
- Default timing is 640x480@60 (800x525 total).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch
SYNC_POL, 0, asserted sync level (0 = active-low)
CNT_W, 10, coordinate width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
clk_i  input  1  pixel clock (divided clock)
rst_  input  1  asynchronous reset, active low
hsync_o  output  1  horizontal sync, level per SYNC_POL
vsync_o  output  1  vertical sync, level per SYNC_POL
video_on_o  output  1  high while pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
pixel_x_o  output  CNT_W  current horizontal position, 0..H_TOTAL-1
pixel_y_o  output  CNT_W  current vertical position, 0..V_TOTAL-1
line_start_o  output  1  one-cycle pulse when pixel_x == 0
frame_start_o  output  1  one-cycle pulse when pixel_x == 0 and pixel_y == 0

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Clock and reset: one clock domain (clk_i); asynchronous, active-low reset (rst_).
- Internal counters h_cnt and v_cnt reset to H_TOTAL-1 and V_TOTAL-1, so the first edge after reset lands on (0,0).
- Every output is a flop, registered from the next counter position. All outputs describe the same position in the same cycle, and no combinational logic drives the sync pins.
- Reset values: hsync_o = vsync_o = ~SYNC_POL (inactive); video_on_o = 0; pixel_x_o = 0; pixel_y_o = 0; line_start_o = 0; frame_start_o = 0.
- First rising edge after rst_ deasserts: position (0,0); video_on_o = 1, line_start_o = 1, frame_start_o = 1.
- h_cnt increments every cycle and wraps from H_TOTAL-1 to 0.
- v_cnt increments only on the h_cnt wrap and wraps from V_TOTAL-1 to 0. A simultaneous h and v wrap yields (0,0).
- hsync asserted for pixel_x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656,751] at defaults.
- vsync asserted for pixel_y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [490,491]; it spans whole lines and changes only when pixel_x == 0.
- Coordinates are not clamped during blanking; consumers gate with video_on_o.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Timing restarts at (0,0) on the first edge after release, with no partial-frame recovery.
- Frame period: exactly H_TOTAL*V_TOTAL cycles (420000). line_start_o period: H_TOTAL cycles.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt_o [15:0].
  - Reset value 0.
  - Increments on every frame_start_o cycle except the first after reset, so the first frame is frame 0.
  - Wraps from 16'hFFFF to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants (640x480@60 values above);
  - a function computing CNT_W from totals;
  - the SYNC_POL encoding constants.
- One sub-module, wrap_counter (params MAX, W; ports clk_i, rst_, en_i, cnt_o, wrap_o):
  - instantiated twice, horizontal with en tied high and vertical with en = horizontal wrap_o;
  - reset value is MAX, so the counters start at H_TOTAL-1 and V_TOTAL-1.

Test Plan:
- Reset check: hold rst_ low 5 cycles -> hsync_o = vsync_o = 1, video_on_o = 0, pixel_x_o = pixel_y_o = 0, strobes 0. Release -> next edge gives (0,0), video_on_o = 1, frame_start_o = 1.
- Horizontal timing over one line:
  - video_on_o high for cycles 0..639;
  - hsync_o low exactly for pixel_x 656..751 (96 cycles);
  - line_start_o pulses every 800 cycles.
- Vertical timing over one frame:
  - vsync_o low for lines 490..491 (1600 cycles), asserting and deasserting at pixel_x == 0;
  - frame_start_o period 420000 cycles;
  - pixel_y_o max 524.
- Wrap corner: at (799,524) -> next cycle (0,0) with line_start_o = frame_start_o = 1; check no extra or missing line.
- Reset mid-frame: assert rst_ at (300,200) -> outputs go to reset values asynchronously (before next edge). Release -> restart at (0,0).
- VGA_FRAME_CNT_EN build: run 3 frames -> frame_cnt_o reads 0, 1, 2 at the successive frame_start_o cycles. Force the counter to 16'hFFFF -> wraps to 0.
